ex3tobcd_seq: RTL and testbench

- Sequential excess-3 to packed-BCD deframer; the reverse path of the BCD-to-excess-3 converter.
- Accepts one 4-bit excess-3 digit per valid/ready transfer and assembles NDIGITS digits into one packed BCD word.
- Flags any digit outside the legal excess-3 range (0011..1100).
- Presents each completed word on a valid/ready output port to downstream display/compare logic.

---
 rtl/ex3tobcd_seq.sv | 165 ++++++++++++++++
 tb/tb_ex3tobcd_seq.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ex3tobcd_seq.sv
// ex3tobcd_seq
//   Sequential excess-3 to packed-BCD deframer. Takes one excess-3 digit per
//   in_valid/in_ready transfer and assembles NDIGITS digits into one packed
//   BCD word. The word is presented on an out_valid/out_ready port. Digits
//   outside 0011..1100 decode to 0000 and raise the per-frame error flag.
//
//   Parameters
//     NDIGITS   digits per frame (1..4); bcd is 4*NDIGITS bits wide
//     MSD_FIRST 1: first accepted digit is the most significant nibble
//               0: first accepted digit is the least significant nibble
//
//   Ports
//     clk       rising-edge clock
//     rst       asynchronous active-high reset
//     in_valid  ex_in holds a digit
//     in_ready  block can accept a digit (high while collecting)
//     ex_in     excess-3 digit
//     out_valid bcd/error hold a completed frame
//     out_ready downstream accepts the frame
//     bcd       packed BCD result
//     error     at least one digit of the frame was illegal
//     bin       (EX3TOBCD_BINARY_OUT_EN only) binary value of the frame
//
//   Build option
//     EX3TOBCD_BINARY_OUT_EN adds the 14-bit bin output and its
//     multiply/accumulate logic. Without it, the port and logic are absent.
module ex3tobcd_seq #(
  parameter int NDIGITS   = 2,
  parameter bit MSD_FIRST = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [3:0]           ex_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [4*NDIGITS-1:0] bcd,
  output logic                 error
`ifdef EX3TOBCD_BINARY_OUT_EN
  ,
  output logic [13:0]          bin
`endif
);

  localparam int W     = 4 * NDIGITS;
  localparam int CNT_W = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NDIGITS - 1);

  typedef enum logic {COLLECT = 1'b0, HOLD = 1'b1} state_t;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic [W-1:0]     acc;
  logic [W-1:0]     acc_upd;
  logic             err_acc;
  logic             accept;
  logic             last;
  logic             illegal;
  logic [3:0]       nib;
  int               pos;

  function automatic logic ex3_illegal(input logic [3:0] e);
    return (e < 4'd3) || (e > 4'd12);
  endfunction

  function automatic logic [3:0] ex3_decode(input logic [3:0] e);
    if (ex3_illegal(e)) return 4'd0;
    return e - 4'd3;
  endfunction

  assign last    = (cnt == CNT_LAST);
  assign illegal = ex3_illegal(ex_in);
  assign nib     = ex3_decode(ex_in);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= COLLECT;
    else     state <= state_next;
  end

  // in_ready/out_valid come straight from the state, so a handshake on the
  // output only reopens the input on the following cycle.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    accept     = 1'b0;
    case (state)
      COLLECT: begin
        in_ready = 1'b1;
        accept   = in_valid;
        if (in_valid && last) state_next = HOLD;
      end
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) state_next = COLLECT;
      end
      default: state_next = COLLECT;
    endcase
  end

  // Word with the incoming digit dropped into its nibble slot.
  always_comb begin
    acc_upd = acc;
    pos     = MSD_FIRST ? (NDIGITS - 1 - int'(cnt)) : int'(cnt);
    for (int i = 0; i < NDIGITS; i++) begin
      if (i == pos) acc_upd[4*i +: 4] = nib;
    end
  end

`ifdef EX3TOBCD_BINARY_OUT_EN
  logic [13:0] bin_acc;
  logic [13:0] bin_upd;
  logic [13:0] weight;

  // Illegal digits already decode to 0, so they add nothing here.
  always_comb begin
    if (MSD_FIRST) bin_upd = (bin_acc * 14'd10) + {10'd0, nib};
    else           bin_upd = bin_acc + (weight * {10'd0, nib});
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      acc     <= '0;
      err_acc <= 1'b0;
      bcd     <= '0;
      error   <= 1'b0;
`ifdef EX3TOBCD_BINARY_OUT_EN
      bin_acc <= '0;
      weight  <= 14'd1;
      bin     <= '0;
`endif
    end else if (accept) begin
      if (last) begin
        // Frame complete: publish directly from the updated word.
        cnt   <= '0;
        bcd   <= acc_upd;
        error <= err_acc | illegal;
`ifdef EX3TOBCD_BINARY_OUT_EN
        bin   <= bin_upd;
`endif
      end else begin
        cnt     <= cnt + 1'b1;
        acc     <= acc_upd;
        err_acc <= err_acc | illegal;
`ifdef EX3TOBCD_BINARY_OUT_EN
        bin_acc <= bin_upd;
        weight  <= weight * 14'd10;
`endif
      end
    end else if (out_valid && out_ready) begin
      // Start the next frame from a clean slate; error is never sticky.
      acc     <= '0;
      err_acc <= 1'b0;
`ifdef EX3TOBCD_BINARY_OUT_EN
      bin_acc <= '0;
      weight  <= 14'd1;
`endif
    end
  end

endmodule

// File: tb/tb_ex3tobcd_seq.sv
// tb_ex3tobcd_seq
//   Bench for ex3tobcd_seq. Instance dut uses NDIGITS=2, MSD_FIRST=1 and is
//   checked through an expected-frame queue; instance dut4 uses NDIGITS=4,
//   MSD_FIRST=0 and is checked by hand-written sequences.
module tb_ex3tobcd_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready, error;
  logic [3:0]  ex_in;
  logic [7:0]  bcd;
  logic        in_valid4, in_ready4, out_valid4, out_ready4, error4;
  logic [3:0]  ex_in4;
  logic [15:0] bcd4;
`ifdef EX3TOBCD_BINARY_OUT_EN
  logic [13:0] bin, bin4;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0]  bcd;
    logic        err;
    logic [13:0] bin;
  } exp_t;

  typedef struct {
    logic [3:0] d0;
    logic [3:0] d1;
    exp_t       e;
  } vec_t;

  exp_t exp_q[$];
  vec_t vecs[9];

  ex3tobcd_seq #(.NDIGITS(2), .MSD_FIRST(1'b1)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .ex_in(ex_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .bcd(bcd), .error(error)
`ifdef EX3TOBCD_BINARY_OUT_EN
    , .bin(bin)
`endif
  );

  ex3tobcd_seq #(.NDIGITS(4), .MSD_FIRST(1'b0)) dut4 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid4), .in_ready(in_ready4), .ex_in(ex_in4),
    .out_valid(out_valid4), .out_ready(out_ready4),
    .bcd(bcd4), .error(error4)
`ifdef EX3TOBCD_BINARY_OUT_EN
    , .bin(bin4)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // One clock: sample outputs at the falling edge (popping the queue on an
  // output handshake), then return 1 time unit after the rising edge.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_frame: got bcd %0h, expected no frame", bcd);
      end else begin
        e = exp_q.pop_front();
        chk("frame_bcd", 32'(bcd), 32'(e.bcd));
        chk("frame_error", 32'(error), 32'(e.err));
`ifdef EX3TOBCD_BINARY_OUT_EN
        chk("frame_bin", 32'(bin), 32'(e.bin));
`endif
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] d);
    int n = 0;
    in_valid = 1'b1;
    ex_in    = d;
    while (!in_ready && n < 50) begin tick(); n++; end
    if (n >= 50) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready stuck at 0, expected 1");
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic send4(input logic [3:0] d);
    int n = 0;
    in_valid4 = 1'b1;
    ex_in4    = d;
    while (!in_ready4 && n < 50) begin tick(); n++; end
    if (n >= 50) begin
      checks++;
      errors++;
      $display("FAIL send4_timeout: in_ready4 stuck at 0, expected 1");
    end
    tick();
    in_valid4 = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin tick(); n++; end
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic push(input logic [7:0] b, input logic e, input logic [13:0] v);
    exp_t x;
    x.bcd = b;
    x.err = e;
    x.bin = v;
    exp_q.push_back(x);
  endtask

  initial begin
    vecs[0] = '{4'h7, 4'hA, '{8'h47, 1'b0, 14'd47}};
    vecs[1] = '{4'hE, 4'h5, '{8'h02, 1'b1, 14'd2}};
    vecs[2] = '{4'h4, 4'h4, '{8'h11, 1'b0, 14'd11}};
    vecs[3] = '{4'h3, 4'h3, '{8'h00, 1'b0, 14'd0}};
    vecs[4] = '{4'hC, 4'hC, '{8'h99, 1'b0, 14'd99}};
    vecs[5] = '{4'h2, 4'hD, '{8'h00, 1'b1, 14'd0}};
    vecs[6] = '{4'hB, 4'h6, '{8'h83, 1'b0, 14'd83}};
    vecs[7] = '{4'hF, 4'h0, '{8'h00, 1'b1, 14'd0}};
    vecs[8] = '{4'hA, 4'h3, '{8'h70, 1'b0, 14'd70}};

    rst = 1'b1; in_valid = 1'b0; ex_in = 4'h0; out_ready = 1'b1;
    in_valid4 = 1'b0; ex_in4 = 4'h0; out_ready4 = 1'b0;
    #1;
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_bcd", 32'(bcd), 32'd0);
    chk("reset_error", 32'(error), 32'd0);
    chk("reset_bcd4", 32'(bcd4), 32'd0);
    tick();
    tick();
    rst = 1'b0;

    // Table of two-digit frames, consumed immediately.
    for (int i = 0; i < 9; i++) begin
      push(vecs[i].e.bcd, vecs[i].e.err, vecs[i].e.bin);
      send(vecs[i].d0);
      chk("mid_frame_out_valid", 32'(out_valid), 32'd0);
      send(vecs[i].d1);
      chk("latency_out_valid", 32'(out_valid), 32'd1);
      chk("hold_in_ready", 32'(in_ready), 32'd0);
    end
    wait_drain();

    // Backpressure: frame 0x23 held for 5 cycles while 0x9 waits.
    out_ready = 1'b0;
    push(8'h23, 1'b0, 14'd23);
    send(4'h5);
    send(4'h6);
    in_valid = 1'b1;
    ex_in    = 4'h9;
    push(8'h65, 1'b0, 14'd65);
    for (int i = 0; i < 5; i++) begin
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_bcd", 32'(bcd), 32'h23);
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("after_hs_in_ready", 32'(in_ready), 32'd1);
    chk("after_hs_out_valid", 32'(out_valid), 32'd0);
    chk("after_hs_bcd_kept", 32'(bcd), 32'h23);
    tick();
    in_valid = 1'b0;
    chk("one_digit_out_valid", 32'(out_valid), 32'd0);
    out_ready = 1'b1;
    send(4'h8);
    chk("bp_frame_out_valid", 32'(out_valid), 32'd1);
    wait_drain();

    // Reset mid-frame: the digit 0x8 accepted before reset is lost.
    send(4'h8);
    rst = 1'b1;
    #1;
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_bcd", 32'(bcd), 32'd0);
    chk("midrst_error", 32'(error), 32'd0);
    tick();
    rst = 1'b0;
    push(8'h13, 1'b0, 14'd13);
    send(4'h4);
    send(4'h6);
    chk("midrst_frame_out_valid", 32'(out_valid), 32'd1);
    wait_drain();

    // Four digits, least significant first.
    send4(4'h4);
    send4(4'h5);
    send4(4'h6);
    chk("lsd_mid_out_valid", 32'(out_valid4), 32'd0);
    send4(4'h7);
    chk("lsd_out_valid", 32'(out_valid4), 32'd1);
    chk("lsd_in_ready", 32'(in_ready4), 32'd0);
    chk("lsd_bcd", 32'(bcd4), 32'h4321);
    chk("lsd_error", 32'(error4), 32'd0);
`ifdef EX3TOBCD_BINARY_OUT_EN
    chk("lsd_bin", 32'(bin4), 32'd4321);
`endif
    out_ready4 = 1'b1;
    tick();
    out_ready4 = 1'b0;
    chk("lsd_hs_out_valid", 32'(out_valid4), 32'd0);
    chk("lsd_hs_in_ready", 32'(in_ready4), 32'd1);
    send4(4'h0);
    send4(4'hC);
    send4(4'h3);
    send4(4'h8);
    chk("lsd2_out_valid", 32'(out_valid4), 32'd1);
    chk("lsd2_bcd", 32'(bcd4), 32'h5090);
    chk("lsd2_error", 32'(error4), 32'd1);
`ifdef EX3TOBCD_BINARY_OUT_EN
    chk("lsd2_bin", 32'(bin4), 32'd5090);
`endif
    out_ready4 = 1'b1;
    tick();
    out_ready4 = 1'b0;
    chk("lsd2_hs_out_valid", 32'(out_valid4), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
